// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// The macro MIPS_CTRL_BNE_EN enables the BNE opcode.
package mips_ctrl_pkg;

  typedef logic [1:0] sel_t;

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3,
    S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR,
    S_RTYPEEX, S_RTYPEWR, S_BEQEX, S_ADDIEX, S_ADDIWR, S_JEX, S_BNEEX
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LB    = 6'b100000,
    OP_SB    = 6'b101000
  } opcode_t;

  localparam sel_t PCSRC_PC4     = 2'b00;
  localparam sel_t PCSRC_BRANCH  = 2'b01;
  localparam sel_t PCSRC_JUMP    = 2'b10;

  localparam sel_t ALUSRCB_REG   = 2'b00;
  localparam sel_t ALUSRCB_FOUR  = 2'b01;
  localparam sel_t ALUSRCB_IMM   = 2'b10;
  localparam sel_t ALUSRCB_BROFF = 2'b11;

  localparam sel_t ALUOP_ADD     = 2'b00;
  localparam sel_t ALUOP_SUB     = 2'b01;
  localparam sel_t ALUOP_FUNCT   = 2'b10;

  function automatic state_t fetch_state(input int k);
    state_t s;
    case (k)
      0:       s = S_FETCH0;
      1:       s = S_FETCH1;
      2:       s = S_FETCH2;
      default: s = S_FETCH3;
    endcase
    return s;
  endfunction

  // Beat k is the last one when k+1 reaches the configured beat count.
  function automatic state_t after_fetch(input int k, input int beats);
    state_t s;
    if (k + 1 >= beats) s = S_DECODE;
    else                s = fetch_state(k + 1);
    return s;
  endfunction

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (opcode_t'(op))
      OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE:                                       ok = 1'b1;
`endif
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Controller <-> datapath bundle: opcode/handshake in, datapath controls out.
interface mips_ctrl_if #(parameter int FETCH_BEATS = 4);
  import mips_ctrl_pkg::*;

  logic [5:0]             op;
  logic                   mem_ready;
  logic                   memwrite, alusrca, memtoreg, iord, pcwrite;
  logic                   brnch, brnch_ne, regwrite, regdst;
  sel_t                   pcsrc, alusrcb, aluop;
  logic [FETCH_BEATS-1:0] irwrite;
  logic                   illegal;

  modport master (
    input  op, mem_ready,
    output memwrite, alusrca, memtoreg, iord, pcwrite,
    output brnch, brnch_ne, regwrite, regdst,
    output pcsrc, alusrcb, aluop, irwrite, illegal
  );

  modport slave (
    output op, mem_ready,
    input  memwrite, alusrca, memtoreg, iord, pcwrite,
    input  brnch, brnch_ne, regwrite, regdst,
    input  pcsrc, alusrcb, aluop, irwrite, illegal
  );

endinterface

// File: rtl/mips_ctrl_decode.sv
// Pure output decode: (state, mem_ready) -> datapath controls.
// brnch_ne is only ever raised when MIPS_CTRL_BNE_EN is defined.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int FETCH_BEATS = 4
) (
  input  state_t                 state,
  input  logic                   mem_ready,
  output logic                   memwrite,
  output logic                   alusrca,
  output logic                   memtoreg,
  output logic                   iord,
  output logic                   pcwrite,
  output logic                   brnch,
  output logic                   brnch_ne,
  output logic                   regwrite,
  output logic                   regdst,
  output sel_t                   pcsrc,
  output sel_t                   alusrcb,
  output sel_t                   aluop,
  output logic [FETCH_BEATS-1:0] irwrite
);

  always_comb begin
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    pcwrite  = 1'b0;
    brnch    = 1'b0;
    brnch_ne = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcsrc    = PCSRC_PC4;
    alusrcb  = ALUSRCB_REG;
    aluop    = ALUOP_ADD;
    irwrite  = '0;

    // Each fetch beat latches its byte only when memory delivers it.
    for (int k = 0; k < FETCH_BEATS; k++)
      if (state == fetch_state(k)) irwrite[k] = mem_ready;

    case (state)
      S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3: begin
        alusrcb = ALUSRCB_FOUR;
        pcwrite = mem_ready;
      end
      S_DECODE:  alusrcb = ALUSRCB_BROFF;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_LBRD:    iord = 1'b1;
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        iord     = 1'b1;
        memwrite = mem_ready;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PCSRC_BRANCH;
        brnch   = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      S_ADDIWR:  regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
`ifdef MIPS_CTRL_BNE_EN
      S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_BRANCH;
        brnch_ne = 1'b1;
      end
`else
      S_BNEEX: ;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM: state register, next-state logic, reset gating.
// Define MIPS_CTRL_BNE_EN to support BNE; otherwise it decodes as illegal.
module mips_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int FETCH_BEATS = 4
) (
  input logic        clk,
  input logic        reset,
  mips_ctrl_if.master bus
);

  state_t                 state, next_state;
  logic                   memwrite, alusrca, memtoreg, iord, pcwrite;
  logic                   brnch, brnch_ne, regwrite, regdst;
  sel_t                   pcsrc, alusrcb, aluop;
  logic [FETCH_BEATS-1:0] irwrite;
  logic                   illegal;

  always_comb begin
    next_state = S_FETCH0;
    case (state)
      S_FETCH0: next_state = bus.mem_ready ? after_fetch(0, FETCH_BEATS) : S_FETCH0;
      S_FETCH1: next_state = bus.mem_ready ? after_fetch(1, FETCH_BEATS) : S_FETCH1;
      S_FETCH2: next_state = bus.mem_ready ? after_fetch(2, FETCH_BEATS) : S_FETCH2;
      S_FETCH3: next_state = bus.mem_ready ? after_fetch(3, FETCH_BEATS) : S_FETCH3;
      S_DECODE: begin
        case (opcode_t'(bus.op))
          OP_LB, OP_SB: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_ADDI:      next_state = S_ADDIEX;
          OP_J:         next_state = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       next_state = S_BNEEX;
`endif
          default:      next_state = S_FETCH0;
        endcase
      end
      S_MEMADR: begin
        if (bus.op == OP_LB)      next_state = S_LBRD;
        else if (bus.op == OP_SB) next_state = S_SBWR;
        else                      next_state = S_FETCH0;
      end
      S_LBRD:    next_state = bus.mem_ready ? S_LBWR : S_LBRD;
      S_SBWR:    next_state = bus.mem_ready ? S_FETCH0 : S_SBWR;
      S_RTYPEEX: next_state = S_RTYPEWR;
      S_ADDIEX:  next_state = S_ADDIWR;
      default:   next_state = S_FETCH0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH0;
    else        state <= next_state;
  end

  mips_ctrl_decode #(.FETCH_BEATS(FETCH_BEATS)) u_decode (
    .state     (state),
    .mem_ready (bus.mem_ready),
    .memwrite  (memwrite),
    .alusrca   (alusrca),
    .memtoreg  (memtoreg),
    .iord      (iord),
    .pcwrite   (pcwrite),
    .brnch     (brnch),
    .brnch_ne  (brnch_ne),
    .regwrite  (regwrite),
    .regdst    (regdst),
    .pcsrc     (pcsrc),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .irwrite   (irwrite)
  );

  assign illegal = (state == S_DECODE) && !op_supported(bus.op);

  // Reset gates every control so no write strobe escapes while reset is held.
  assign bus.memwrite = reset & memwrite;
  assign bus.alusrca  = reset & alusrca;
  assign bus.memtoreg = reset & memtoreg;
  assign bus.iord     = reset & iord;
  assign bus.pcwrite  = reset & pcwrite;
  assign bus.brnch    = reset & brnch;
  assign bus.brnch_ne = reset & brnch_ne;
  assign bus.regwrite = reset & regwrite;
  assign bus.regdst   = reset & regdst;
  assign bus.illegal  = reset & illegal;
  assign bus.pcsrc    = reset ? pcsrc   : PCSRC_PC4;
  assign bus.alusrcb  = reset ? alusrcb : ALUSRCB_REG;
  assign bus.aluop    = reset ? aluop   : ALUOP_ADD;
  assign bus.irwrite  = reset ? irwrite : '0;

endmodule

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 SHALL have parameter FETCH_BEATS, default 4, range 1..4: number of byte fetch cycles per instruction.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-004 op  in  6  instruction opcode, sampled in DECODE.
REQ-005 mem_ready  in  1  memory handshake; 1 = access completes this cycle.
REQ-006 memwrite, alusrca, memtoreg, iord, pcwrite, brnch, brnch_ne, regwrite, regdst  out  1 each  datapath controls.
REQ-007 pcsrc, alusrcb, aluop  out  2 each  mux selects / ALU op class.
REQ-008 irwrite  out  FETCH_BEATS  one-hot instruction-register byte enable.
REQ-009 illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-010 States SHALL be FETCH[0..FETCH_BEATS-1], DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, ADDIEX, ADDIWR, JEX, plus BNEEX when enabled (REQ-030).
REQ-011 Outputs SHALL be 0 except as listed per state; all outputs decode from current state and mem_ready only.
REQ-012 FETCHk: alusrcb=01, irwrite[k]=mem_ready, pcwrite=mem_ready; advance to FETCHk+1 (last beat -> DECODE) only when mem_ready=1, else hold.
REQ-013 DECODE: alusrcb=11; next by op: LB/SB(100000/101000)->MEMADR, RTYPE(000000)->RTYPEEX, BEQ(000100)->BEQEX, ADDI(001000)->ADDIEX, J(000010)->JEX, BNE(000101)->BNEEX if enabled.
REQ-014 DECODE with any other op: illegal=1 for that cycle, next FETCH0.
REQ-015 MEMADR: alusrca=1, alusrcb=10; next LBRD if op=LB, SBWR if op=SB.
REQ-016 LBRD: iord=1; holds until mem_ready=1, then LBWR.
REQ-017 LBWR: regwrite=1, memtoreg=1; next FETCH0.
REQ-018 SBWR: iord=1, memwrite=mem_ready; holds until mem_ready=1, then FETCH0.
REQ-019 RTYPEEX: alusrca=1, aluop=10 -> RTYPEWR; RTYPEWR: regdst=1, regwrite=1 -> FETCH0.
REQ-020 BEQEX: alusrca=1, aluop=01, pcsrc=01, brnch=1 -> FETCH0.
REQ-021 ADDIEX: alusrca=1, alusrcb=10 -> ADDIWR; ADDIWR: regwrite=1 -> FETCH0.
REQ-022 JEX: pcsrc=10, pcwrite=1 -> FETCH0.
REQ-023 Non-fetch, non-memory states SHALL last exactly one cycle; op changes outside DECODE/MEMADR SHALL have no effect.
REQ-024 Latency with mem_ready=1 always: LB FETCH_BEATS+4 cycles, SB/RTYPE/ADDI FETCH_BEATS+3, BEQ/BNE/J FETCH_BEATS+2.

Reset
REQ-025 reset=0 at a rising edge SHALL force state FETCH0 regardless of current state, including mid-stall.
REQ-026 While reset=0, all outputs SHALL be forced 0 combinationally (no pcwrite/irwrite/memwrite during reset).
REQ-027 First cycle after release SHALL be FETCH0 with irwrite[0]=pcwrite=mem_ready.

Configuration
REQ-030 Macro MIPS_CTRL_BNE_EN defined: BNEEX exists; alusrca=1, aluop=01, pcsrc=01, brnch_ne=1 -> FETCH0.
REQ-031 Macro undefined: op 000101 SHALL take the illegal path (REQ-014); brnch_ne tied 0.

Structure
REQ-032 Package mips_ctrl_pkg SHALL hold the state enum, opcode enum (LB, SB, RTYPE, BEQ, BNE, ADDI, J), and pcsrc/alusrcb/aluop encoding constants.
REQ-033 Sub-module mips_ctrl_decode SHALL map (state, mem_ready) to all control outputs combinationally; mips_ctrl_fsm holds the state register and next-state logic.

Verification
REQ-034 FETCH_BEATS=4, mem_ready=1, op=LB: irwrite 0001,0010,0100,1000 then DECODE, MEMADR, LBRD(iord=1), LBWR(regwrite=memtoreg=1); back at FETCH0 on cycle 9.
REQ-035 op=SB, mem_ready=0 for 3 cycles in SBWR: state holds, memwrite=0 for 3 cycles, memwrite=1 exactly once when mem_ready=1.
REQ-036 mem_ready=0 during FETCH2: irwrite=0, pcwrite=0, state held until mem_ready=1, then irwrite=0100.
REQ-037 op=111111 in DECODE: illegal=1 one cycle, next state FETCH0; op=000101 illegal with macro off, brnch_ne=1 in BNEEX with macro on.
REQ-038 reset=0 asserted in LBRD: all outputs 0 same cycle, FETCH0 after next edge; FETCH_BEATS=1 run of RTYPE: irwrite width 1, RTYPE complete in 4 cycles.
